exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline, directly downstream of the ID control unit and the ID/EXE register.
- Consumes exe_cmd, S, B, mem_r_en, mem_w_en and wb_en, together with operands already resolved upstream, with val2 supplied already shifted or immediate-formed.
- Performs the ALU operation and maintains the NZCV status register.
- Computes the branch target and registers the results into the EXE/MEM pipeline register, with freeze support.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 4, destination register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- freeze  in  1  memory-stage stall; holds all state in this stage.
- valid_in  in  1  the ID/EXE slot holds a real (non-bubble) instruction.
- exe_cmd  in  4  ALU command from the ID control unit.
- s_in  in  1  S bit as passed through by ID.
- b_in  in  1  branch.
- mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control from ID.
- pc_in  in  DATA_W  PC+4 of the instruction.
- val1  in  DATA_W  Rn value.
- val2  in  DATA_W  second operand.
- st_val_in  in  DATA_W  Rd value for STR.
- imm24  in  24  branch offset.
- dest_in  in  REG_W  destination register.
- branch_taken  out  1  combinational; upstream flushes IF/ID on it.
- branch_addr  out  DATA_W  combinational branch target.
- status  out  4  registered NZCV (bit3 = N … bit0 = V).
- alu_res, st_val  out  DATA_W  EXE/MEM register.
- dest  out  REG_W  EXE/MEM register.
- wb_en, mem_r_en, mem_w_en, valid  out  1 each  EXE/MEM register.

Behaviour:
- Reset: rst_n=0 at a rising clk edge clears status and every EXE/MEM output to 0. It overrides freeze and takes effect mid-instruction; the in-flight instruction is dropped.
- ALU (combinational), with C = status[1]:
  - 0001 MOV: res=val2.
  - 1001 MVN: res=~val2.
  - 0010 ADD: val1+val2.
  - 0011 ADC: val1+val2+C.
  - 0100 SUB/CMP: val1-val2.
  - 0101 SBC: val1-val2-(~C).
  - 0110 AND/TST: val1&val2.
  - 0111 ORR: val1|val2.
  - 1000 EOR: val1^val2.
  - Any other code: res=0 and no flag change.
- Flags: N=res[31]; Z=(res==0).
  - Arithmetic: computed at DATA_W+1 bits. C is the carry-out for add/adc, and the NOT-borrow (ARM convention) for sub/sbc. V is signed overflow.
  - Logical/move ops: C and V keep their old values.
- Status update: status<=new flags only when valid_in & s_in & ~mem_r_en_in & ~mem_w_en_in & ~b_in & ~freeze. Because ID passes S=1 for LDR, that instruction must not touch flags.
- Freeze: when freeze=1, status and the whole EXE/MEM register hold. The same instruction is re-presented next cycle. ADC/SBC must not see their own carry, hence no update while frozen.
- Pipeline register: when not frozen, it loads alu_res, st_val, dest and the control bits with latency 1.
  - valid <= valid_in.
  - wb_en, mem_r_en and mem_w_en are each ANDed with valid_in, so a bubble never writes.
  - For LDR/STR, alu_res is the address val1+val2 (exe_cmd 0010).
- Branch: branch_addr = pc_in + (sign_extend(imm24) << 2), computed modulo 2^DATA_W with wrap-around.
  - branch_taken = valid_in & b_in & ~freeze.
  - A branch writes nothing: wb_en and mem enables are forced to 0 in the register.
- Simultaneous reset and freeze: reset wins. Simultaneous s_in and b_in: no flag update.

Decomposition:
- Shared package arm_pkg:
  - exe_cmd localparams EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR.
  - NZCV bit-index constants.
- One sub-module, exe_alu: purely combinational, producing res and NZCV from exe_cmd, val1, val2 and carry_in. The top level holds the status register, branch adder and EXE/MEM register.

Test Plan:
- Reset then ADD with S=1, val1=0x7FFFFFFF, val2=1 -> next cycle alu_res=0x80000000, status=4'b1001 (N=1, V=1).
- SUB with S=1, 5-5, then ADC with S=0, val1=2, val2=3 -> after SUB status=4'b0110; ADC alu_res=6 using C=1; status unchanged.
- LDR (exe_cmd=0010, s=1, mem_r_en=1), val1=0x100, val2=8, status preloaded 0 -> alu_res=0x108, mem_r_en=1, wb_en=1, status stays 0.
- Branch b_in=1, pc_in=0x20, imm24=0xFFFFFE -> branch_taken=1 same cycle, branch_addr=0x18; registered wb_en=mem_w_en=0.
- Freeze held 3 cycles during ADC with S=1 and C=1, inputs constant -> outputs and status frozen, no branch_taken. After release there is exactly one update, with the result computed from the original C.
- Assert rst_n=0 for one cycle while freeze=1 and a valid STR is in flight -> all outputs and status are 0 next cycle; mem_w_en never reaches 1.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: execute commands, NZCV bit positions
// and the signed-overflow helpers used by the ALU.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Addition overflows when both operands share a sign that the result lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction overflows when operand signs differ and the result flips from a.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU of the execute stage: result plus candidate NZCV flags.
// flag_upd is low for unknown commands so the caller leaves status untouched.
module exe_alu
    import arm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic              carry_in,
    input  logic              ovf_in,
    output logic [DATA_W-1:0] res,
    output logic [3:0]        nzcv,
    output logic              flag_upd
);

    logic [DATA_W:0]   sum_s;
    logic [DATA_W-1:0] res_s;
    logic              c_s;
    logic              v_s;
    logic              upd_s;
    logic [DATA_W:0]   cin_ext_s;

    assign cin_ext_s = {{DATA_W{1'b0}}, carry_in};

    // Operation decode; subtraction uses a + ~b + 1 so bit DATA_W is the not-borrow.
    always_comb begin
        sum_s = {(DATA_W+1){1'b0}};
        res_s = {DATA_W{1'b0}};
        c_s   = carry_in;
        v_s   = ovf_in;
        upd_s = 1'b0;
        case (exe_cmd)
            EXE_MOV: begin
                res_s = val2;
                upd_s = 1'b1;
            end
            EXE_MVN: begin
                res_s = ~val2;
                upd_s = 1'b1;
            end
            EXE_ADD, EXE_ADC: begin
                sum_s = {1'b0, val1} + {1'b0, val2}
                      + ((exe_cmd == EXE_ADC) ? cin_ext_s : {(DATA_W+1){1'b0}});
                res_s = sum_s[DATA_W-1:0];
                c_s   = sum_s[DATA_W];
                v_s   = add_ovf(val1[DATA_W-1], val2[DATA_W-1], sum_s[DATA_W-1]);
                upd_s = 1'b1;
            end
            EXE_SUB, EXE_SBC: begin
                sum_s = {1'b0, val1} + {1'b0, ~val2}
                      + ((exe_cmd == EXE_SBC) ? cin_ext_s : {{DATA_W{1'b0}}, 1'b1});
                res_s = sum_s[DATA_W-1:0];
                c_s   = sum_s[DATA_W];
                v_s   = sub_ovf(val1[DATA_W-1], val2[DATA_W-1], sum_s[DATA_W-1]);
                upd_s = 1'b1;
            end
            EXE_AND: begin
                res_s = val1 & val2;
                upd_s = 1'b1;
            end
            EXE_ORR: begin
                res_s = val1 | val2;
                upd_s = 1'b1;
            end
            EXE_EOR: begin
                res_s = val1 ^ val2;
                upd_s = 1'b1;
            end
            default: begin
                res_s = {DATA_W{1'b0}};
                upd_s = 1'b0;
            end
        endcase
    end

    assign res      = res_s;
    assign nzcv     = {res_s[DATA_W-1], (res_s == {DATA_W{1'b0}}), c_s, v_s};
    assign flag_upd = upd_s;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ALU, NZCV status register, branch target adder and the
// EXE/MEM pipeline register, all held while the memory stage freezes.
module exe_stage
    import arm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic              b_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] st_val_in,
    input  logic [23:0]       imm24,
    input  logic [REG_W-1:0]  dest_in,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [REG_W-1:0]  dest,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              valid
);

    logic [3:0]        status_q,   status_d;
    logic [DATA_W-1:0] alu_res_q,  alu_res_d;
    logic [DATA_W-1:0] st_val_q,   st_val_d;
    logic [REG_W-1:0]  dest_q,     dest_d;
    logic              wb_en_q,    wb_en_d;
    logic              mem_r_en_q, mem_r_en_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              valid_q,    valid_d;

    logic [DATA_W-1:0] alu_res_s;
    logic [3:0]        alu_nzcv_s;
    logic              alu_upd_s;
    logic              flag_wr_s;
    logic              wr_ok_s;
    logic [DATA_W-1:0] br_off_s;

    exe_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .exe_cmd  (exe_cmd),
        .val1     (val1),
        .val2     (val2),
        .carry_in (status_q[FLAG_C]),
        .ovf_in   (status_q[FLAG_V]),
        .res      (alu_res_s),
        .nzcv     (alu_nzcv_s),
        .flag_upd (alu_upd_s)
    );

    // Loads and stores carry S=1 from ID but must never touch the flags.
    assign flag_wr_s = valid_in & s_in & ~mem_r_en_in & ~mem_w_en_in & ~b_in
                     & ~freeze & alu_upd_s;
    assign wr_ok_s   = valid_in & ~b_in;

    assign br_off_s     = {{(DATA_W-26){imm24[23]}}, imm24, 2'b00};
    assign branch_addr  = pc_in + br_off_s;
    assign branch_taken = valid_in & b_in & ~freeze;

    // Next-state for status and the EXE/MEM register; freeze holds everything.
    always_comb begin
        status_d   = status_q;
        alu_res_d  = alu_res_q;
        st_val_d   = st_val_q;
        dest_d     = dest_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        valid_d    = valid_q;
        if (flag_wr_s) begin
            status_d = alu_nzcv_s;
        end else begin
            status_d = status_q;
        end
        if (!freeze) begin
            alu_res_d  = alu_res_s;
            st_val_d   = st_val_in;
            dest_d     = dest_in;
            wb_en_d    = wb_en_in & wr_ok_s;
            mem_r_en_d = mem_r_en_in & wr_ok_s;
            mem_w_en_d = mem_w_en_in & wr_ok_s;
            valid_d    = valid_in;
        end else begin
            valid_d    = valid_q;
        end
    end

    // State registers with synchronous active-low reset overriding freeze.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q   <= 4'b0000;
            alu_res_q  <= {DATA_W{1'b0}};
            st_val_q   <= {DATA_W{1'b0}};
            dest_q     <= {REG_W{1'b0}};
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            status_q   <= status_d;
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            valid_q    <= valid_d;
        end
    end

    assign status   = status_q;
    assign alu_res  = alu_res_q;
    assign st_val   = st_val_q;
    assign dest     = dest_q;
    assign wb_en    = wb_en_q;
    assign mem_r_en = mem_r_en_q;
    assign mem_w_en = mem_w_en_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        valid_in;
    logic [3:0]  exe_cmd;
    logic        s_in;
    logic        b_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        wb_en_in;
    logic [31:0] pc_in;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val_in;
    logic [23:0] imm24;
    logic [3:0]  dest_in;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        valid;

    int checks_cnt = 0;
    int errors_cnt = 0;

    exe_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .valid_in     (valid_in),
        .exe_cmd      (exe_cmd),
        .s_in         (s_in),
        .b_in         (b_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .wb_en_in     (wb_en_in),
        .pc_in        (pc_in),
        .val1         (val1),
        .val2         (val2),
        .st_val_in    (st_val_in),
        .imm24        (imm24),
        .dest_in      (dest_in),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .status       (status),
        .alu_res      (alu_res),
        .st_val       (st_val),
        .dest         (dest),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .valid        (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cmd, input logic s, input logic b,
                         input logic mr, input logic mw, input logic wb,
                         input logic [31:0] a, input logic [31:0] bv);
        valid_in    = v;
        exe_cmd     = cmd;
        s_in        = s;
        b_in        = b;
        mem_r_en_in = mr;
        mem_w_en_in = mw;
        wb_en_in    = wb;
        val1        = a;
        val2        = bv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        pc_in = 32'h0; st_val_in = 32'h0; imm24 = 24'h0; dest_in = 4'h0;
        tick(); tick();
        check("rst_status", {28'h0, status}, 32'h0);
        check("rst_valid",  {31'h0, valid},  32'h0);
        check("rst_alu",    alu_res,         32'h0);

        // ADD with signed overflow
        rst_n = 1'b1;
        drive(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h1);
        dest_in = 4'h3;
        tick();
        check("add_res",    alu_res,          32'h8000_0000);
        check("add_status", {28'h0, status},  32'h9);
        check("add_dest",   {28'h0, dest},    32'h3);
        check("add_wb",     {31'h0, wb_en},   32'h1);

        // SUB 5-5 sets Z and C
        drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 32'h5);
        tick();
        check("sub_res",    alu_res,         32'h0);
        check("sub_status", {28'h0, status}, 32'h6);

        // ADC without S uses C=1, flags untouched
        drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 32'h3);
        tick();
        check("adc_res",    alu_res,         32'h6);
        check("adc_status", {28'h0, status}, 32'h6);

        // Reset to clear status, then LDR with S=1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h8);
        tick();
        check("ldr_res",    alu_res,          32'h108);
        check("ldr_mr",     {31'h0, mem_r_en},32'h1);
        check("ldr_wb",     {31'h0, wb_en},   32'h1);
        check("ldr_status", {28'h0, status},  32'h0);

        // Branch backwards by two words; control writes forced off
        drive(1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 32'h1);
        pc_in = 32'h20; imm24 = 24'hFF_FFFE;
        #1;
        check("br_taken", {31'h0, branch_taken}, 32'h1);
        check("br_addr",  branch_addr,           32'h18);
        tick();
        check("br_wb",     {31'h0, wb_en},    32'h0);
        check("br_mw",     {31'h0, mem_w_en}, 32'h0);
        check("br_valid",  {31'h0, valid},    32'h1);
        check("br_status", {28'h0, status},   32'h0);

        // Positive offset wrap-around at top of address space
        pc_in = 32'hFFFF_FFFC; imm24 = 24'h00_0002;
        #1;
        check("br_wrap", branch_addr, 32'h4);

        // Set C=1 via SUB, then freeze ADC S=1 for three cycles
        drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5, 32'h5);
        tick();
        check("pre_frz_status", {28'h0, status}, 32'h6);
        drive(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_res",    alu_res,         32'h0);
            check("frz_status", {28'h0, status}, 32'h6);
        end
        b_in = 1'b1;
        #1;
        check("frz_no_branch", {31'h0, branch_taken}, 32'h0);
        b_in = 1'b0;
        freeze = 1'b0;
        tick();
        check("unfrz_res",    alu_res,         32'h4);
        check("unfrz_status", {28'h0, status}, 32'h0);

        // Reset wins over freeze while a valid STR is presented
        drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h4);
        st_val_in = 32'hDEAD_BEEF; dest_in = 4'h7;
        freeze = 1'b1; rst_n = 1'b0;
        tick();
        check("rf_alu",    alu_res,          32'h0);
        check("rf_mw",     {31'h0, mem_w_en},32'h0);
        check("rf_valid",  {31'h0, valid},   32'h0);
        check("rf_wb",     {31'h0, wb_en},   32'h0);
        check("rf_stval",  st_val,           32'h0);
        check("rf_status", {28'h0, status},  32'h0);
        rst_n = 1'b1;
        tick();
        check("rf_hold_mw", {31'h0, mem_w_en}, 32'h0);

        // Unknown command leaves flags alone and yields zero
        freeze = 1'b0;
        drive(1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h2);
        tick();
        check("neg_status", {28'h0, status}, 32'h8);
        drive(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9, 32'h9);
        tick();
        check("bad_res",    alu_res,         32'h0);
        check("bad_status", {28'h0, status}, 32'h8);

        // Bubble never writes
        drive(1'b0, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1, 32'h1);
        tick();
        check("bub_wb",     {31'h0, wb_en},    32'h0);
        check("bub_mr",     {31'h0, mem_r_en}, 32'h0);
        check("bub_status", {28'h0, status},   32'h8);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
